// File: rtl/digital_equalizer_pkg.sv
// Shared definitions for the digital equalizer.
//   DEQ_DATA_W : default sample width
//   Q26_UNITY  : unity gain in unsigned Q2.6 (64)
//   Q26_FRAC   : fractional bits of the Q2.6 gains
//   EQ_W       : width of the EQ_out magnitude class (5)
//   sat_to_width : clamp a wide signed value to a two's-complement width
//   bit_len      : bit length of |v|, clipped to 31
package digital_equalizer_pkg;

  localparam int DEQ_DATA_W = 16;
  localparam int Q26_UNITY  = 64;
  localparam int Q26_FRAC   = 6;
  localparam int EQ_W       = 5;
  localparam int EQ_MAX     = 31;
  localparam int CALC_W     = 64;

  typedef logic signed [CALC_W-1:0] calc_t;

  function automatic calc_t sat_to_width(input calc_t v, input int w);
    calc_t max_v;
    calc_t min_v;
    max_v = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    min_v = -max_v - calc_t'(1);
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

  function automatic logic [EQ_W-1:0] bit_len(input calc_t v);
    logic [CALC_W-1:0] mag;
    int len;
    mag = (v < 0) ? -v : v;
    len = 0;
    for (int i = 0; i < CALC_W; i++) begin
      if (mag[i]) len = i + 1;
    end
    if (len > EQ_MAX) len = EQ_MAX;
    return len[EQ_W-1:0];
  endfunction

endpackage

// File: rtl/deq_band_split.sv
// Per-channel one-pole low/high band split.
// Holds the left and right low-band states; the channel selected by lr is
// read combinationally and written back on the clock edge when en is high.
// Ports:
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset, clears both channel states
//   en      : commit lo_new into the selected channel state
//   lr      : channel select (0 = left, 1 = right)
//   x       : signed input sample
//   lo_new  : updated low-band value for the selected channel
//   hi      : high-band residue x - lo_new
module deq_band_split
  import digital_equalizer_pkg::*;
#(
  parameter int DATA_W      = DEQ_DATA_W,
  parameter int ALPHA_SHIFT = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     lr,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W+1:0] lo_new,
  output logic signed [DATA_W+1:0] hi
);

  localparam int LO_W = DATA_W + 2;
  localparam int DL_W = LO_W + 1;

  logic signed [LO_W-1:0] lo_l;
  logic signed [LO_W-1:0] lo_r;
  logic signed [LO_W-1:0] lo_sel;
  logic signed [LO_W-1:0] x_ext;
  logic signed [DL_W-1:0] delta;

  // The low band tracks the input, so lo stays inside the sample range; the
  // extra delta bit only keeps x - lo exact before the shift.
  always_comb begin
    lo_sel = lr ? lo_r : lo_l;
    x_ext  = LO_W'(x);
    delta  = DL_W'(x_ext) - DL_W'(lo_sel);
    lo_new = lo_sel + LO_W'(delta >>> ALPHA_SHIFT);
    hi     = x_ext - lo_new;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lo_l <= '0;
      lo_r <= '0;
    end else if (en) begin
      if (lr) lo_r <= lo_new;
      else    lo_l <= lo_new;
    end
  end

endmodule

// File: rtl/digital_equalizer.sv
// Two-band stereo equalizer: one-pole low/high split per channel, then a
// Q2.6 gain on each band, recombined and saturated. Latency is two clocks
// from the strobe edge; one sample per cycle may be in flight at each stage.
// Parameters:
//   DATA_W      : sample width (two's complement)
//   ALPHA_SHIFT : low-band smoothing shift, 1..8
//   LOW_GAIN    : low-band gain, unsigned Q2.6 (0..255, 64 = unity)
//   HIGH_GAIN   : high-band gain, unsigned Q2.6 (0..255, 64 = unity)
// Ports:
//   SCK     : clock, rising edge
//   reset_n : synchronous active-low reset
//   SFS     : frame sync, each 0->1 transition introduces one sample
//   D       : signed input sample, taken in the strobe cycle
//   LR      : channel of D (0 = left, 1 = right)
//   BYPASS  : only when DEQ_BYPASS_EN is defined; passes x through
//   D_out   : equalized, saturated sample, held between updates
//   EQ_out  : bit length of |y - x| for the last output (unsaturated y)
// Build option: define DEQ_BYPASS_EN to add the BYPASS input.
module digital_equalizer
  import digital_equalizer_pkg::*;
#(
  parameter int DATA_W      = DEQ_DATA_W,
  parameter int ALPHA_SHIFT = 4,
  parameter int LOW_GAIN    = Q26_UNITY,
  parameter int HIGH_GAIN   = Q26_UNITY
) (
  input  logic                     SCK,
  input  logic                     reset_n,
  input  logic                     SFS,
  input  logic signed [DATA_W-1:0] D,
  input  logic                     LR,
`ifdef DEQ_BYPASS_EN
  input  logic                     BYPASS,
`endif
  output logic signed [DATA_W-1:0] D_out,
  output logic        [EQ_W-1:0]   EQ_out
);

  localparam int LO_W   = DATA_W + 2;
  localparam int PROD_W = DATA_W + 12;

  localparam logic signed [PROD_W-1:0] LOW_G_S  = PROD_W'(LOW_GAIN);
  localparam logic signed [PROD_W-1:0] HIGH_G_S = PROD_W'(HIGH_GAIN);

  logic                     sfs_q;
  logic                     strobe;

  logic signed [DATA_W-1:0] x_p0;
  logic                     lr_p0;
  logic                     vld_p0;

  logic signed [LO_W-1:0]   lo_new;
  logic signed [LO_W-1:0]   hi;

  logic signed [LO_W-1:0]   lo_p1;
  logic signed [LO_W-1:0]   hi_p1;
  logic signed [DATA_W-1:0] x_p1;
  logic                     vld_p1;

  logic signed [PROD_W-1:0] acc;
  logic signed [PROD_W-1:0] y_full;
  calc_t                    corr;
  logic signed [DATA_W-1:0] d_nxt;
  logic        [EQ_W-1:0]   eq_nxt;

`ifdef DEQ_BYPASS_EN
  logic                     byp_p0;
  logic                     byp_p1;
`endif

  // ---- stage 0: edge detect and sample capture ----
  // sfs_q resets high so SFS already high at reset release is not a new frame.
  assign strobe = SFS & ~sfs_q;

  always_ff @(posedge SCK) begin
    if (!reset_n) begin
      sfs_q  <= 1'b1;
      vld_p0 <= 1'b0;
    end else begin
      sfs_q  <= SFS;
      vld_p0 <= strobe;
    end
  end

  always_ff @(posedge SCK) begin
    if (strobe) begin
      x_p0  <= D;
      lr_p0 <= LR;
`ifdef DEQ_BYPASS_EN
      byp_p0 <= BYPASS;
`endif
    end
  end

  // ---- stage 1: band split and per-channel state update ----
  deq_band_split #(
    .DATA_W      (DATA_W),
    .ALPHA_SHIFT (ALPHA_SHIFT)
  ) u_band_split (
    .clk     (SCK),
    .reset_n (reset_n),
    .en      (vld_p0),
    .lr      (lr_p0),
    .x       (x_p0),
    .lo_new  (lo_new),
    .hi      (hi)
  );

  always_ff @(posedge SCK) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= vld_p0;
  end

  always_ff @(posedge SCK) begin
    if (vld_p0) begin
      lo_p1 <= lo_new;
      hi_p1 <= hi;
      x_p1  <= x_p0;
`ifdef DEQ_BYPASS_EN
      byp_p1 <= byp_p0;
`endif
    end
  end

  // ---- stage 2: band gains, recombine, saturate ----
  // PROD_W leaves headroom for two 255x products of an 18-bit band value.
  always_comb begin
    acc    = PROD_W'(lo_p1) * LOW_G_S + PROD_W'(hi_p1) * HIGH_G_S;
    y_full = acc >>> Q26_FRAC;
    corr   = calc_t'(y_full) - calc_t'(x_p1);
    d_nxt  = DATA_W'(sat_to_width(calc_t'(y_full), DATA_W));
    eq_nxt = bit_len(corr);
`ifdef DEQ_BYPASS_EN
    if (byp_p1) begin
      d_nxt  = x_p1;
      eq_nxt = '0;
    end
`endif
  end

  always_ff @(posedge SCK) begin
    if (!reset_n) begin
      D_out  <= '0;
      EQ_out <= '0;
    end else if (vld_p1) begin
      D_out  <= d_nxt;
      EQ_out <= eq_nxt;
    end
  end

endmodule

// File: tb/tb_digital_equalizer.sv
// Scoreboard bench for digital_equalizer: three instances (unity gains,
// low-band only, 255/255 gains) share one stimulus stream; each has its own
// expectation queue keyed by the cycle its output is due.
module tb_digital_equalizer;

  localparam int DW = 16;

  logic                 SCK = 1'b0;
  logic                 reset_n;
  logic                 SFS;
  logic signed [DW-1:0] D;
  logic                 LR;

  logic signed [DW-1:0] d_u, d_l, d_h;
  logic [4:0]           eq_u, eq_l, eq_h;

  always #5 SCK = ~SCK;

  digital_equalizer #(.DATA_W(DW), .ALPHA_SHIFT(4), .LOW_GAIN(64), .HIGH_GAIN(64)) u_unity (
    .SCK(SCK), .reset_n(reset_n), .SFS(SFS), .D(D), .LR(LR),
`ifdef DEQ_BYPASS_EN
    .BYPASS(1'b0),
`endif
    .D_out(d_u), .EQ_out(eq_u)
  );

  digital_equalizer #(.DATA_W(DW), .ALPHA_SHIFT(4), .LOW_GAIN(64), .HIGH_GAIN(0)) u_low (
    .SCK(SCK), .reset_n(reset_n), .SFS(SFS), .D(D), .LR(LR),
`ifdef DEQ_BYPASS_EN
    .BYPASS(1'b0),
`endif
    .D_out(d_l), .EQ_out(eq_l)
  );

  digital_equalizer #(.DATA_W(DW), .ALPHA_SHIFT(4), .LOW_GAIN(255), .HIGH_GAIN(255)) u_hot (
    .SCK(SCK), .reset_n(reset_n), .SFS(SFS), .D(D), .LR(LR),
`ifdef DEQ_BYPASS_EN
    .BYPASS(1'b0),
`endif
    .D_out(d_h), .EQ_out(eq_h)
  );

  typedef struct packed {
    int          due;
    logic [15:0] d;
    logic [4:0]  eq;
  } exp_t;

  exp_t q_u[$];
  exp_t q_l[$];
  exp_t q_h[$];

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;

  always @(posedge SCK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act_d, input logic [4:0] act_eq,
                       input logic [15:0] exp_d, input logic [4:0] exp_eq);
    n_vec++;
    if (act_d !== exp_d || act_eq !== exp_eq) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got D_out=%h EQ_out=%0d, expected D_out=%h EQ_out=%0d",
               name, cyc, act_d, act_eq, exp_d, exp_eq);
    end
  endtask

  task automatic exp_u(input int due, input logic [15:0] d, input logic [4:0] eq);
    exp_t e;
    e.due = due; e.d = d; e.eq = eq;
    q_u.push_back(e);
  endtask

  task automatic exp_l(input int due, input logic [15:0] d, input logic [4:0] eq);
    exp_t e;
    e.due = due; e.d = d; e.eq = eq;
    q_l.push_back(e);
  endtask

  task automatic exp_h(input int due, input logic [15:0] d, input logic [4:0] eq);
    exp_t e;
    e.due = due; e.d = d; e.eq = eq;
    q_h.push_back(e);
  endtask

  // Monitors: compare each instance when its front expectation comes due.
  always @(negedge SCK) begin
    if (q_u.size() > 0 && q_u[0].due == cyc) begin
      check("unity", d_u, eq_u, q_u[0].d, q_u[0].eq);
      void'(q_u.pop_front());
    end
  end

  always @(negedge SCK) begin
    if (q_l.size() > 0 && q_l[0].due == cyc) begin
      check("lowband", d_l, eq_l, q_l[0].d, q_l[0].eq);
      void'(q_l.pop_front());
    end
  end

  always @(negedge SCK) begin
    if (q_h.size() > 0 && q_h[0].due == cyc) begin
      check("hotgain", d_h, eq_h, q_h[0].d, q_h[0].eq);
      void'(q_h.pop_front());
    end
  end

  // Raise SFS with a new sample; output is due on the third edge from here.
  task automatic start(input logic [15:0] x, input logic lr, output int due);
    @(posedge SCK); #1;
    SFS = 1'b1; D = x; LR = lr;
    due = cyc + 3;
  endtask

  // Keep SFS high for 'extra' more cycles with changing D/LR, then drop it.
  task automatic finish(input int extra);
    for (int i = 0; i < extra; i++) begin
      @(posedge SCK); #1;
      D = D ^ 16'h0F0F; LR = ~LR;
    end
    @(posedge SCK); #1;
    SFS = 1'b0;
  endtask

  task automatic do_reset(input logic sfs_level);
    @(posedge SCK); #1;
    reset_n = 1'b0; SFS = sfs_level;
    repeat (2) @(posedge SCK);
    #1 reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge SCK);
  endtask

  task automatic check_reset_state();
    @(negedge SCK);
    check("rst_unity", d_u, eq_u, 16'h0000, 5'd0);
    check("rst_low",   d_l, eq_l, 16'h0000, 5'd0);
    check("rst_hot",   d_h, eq_h, 16'h0000, 5'd0);
  endtask

  initial begin
    int due;
    reset_n = 1'b1; SFS = 1'b0; D = '0; LR = 1'b0;

    do_reset(1'b0);
    check_reset_state();

    // Unity gains pass samples through unchanged.
    start(16'h0000, 1'b0, due); exp_u(due, 16'h0000, 5'd0); finish(0);
    start(16'hFFFF, 1'b0, due); exp_u(due, 16'hFFFF, 5'd0); finish(0);
    start(16'h7FFF, 1'b1, due); exp_u(due, 16'h7FFF, 5'd0); finish(0);

    // SFS held high five cycles: one output, then held.
    start(16'h1357, 1'b0, due);
    exp_u(due, 16'h1357, 5'd0);
    for (int i = 1; i <= 5; i++) exp_u(due + i, 16'h1357, 5'd0);
    finish(4);
    idle(6);

    // Left-channel step into the low-band-only instance.
    do_reset(1'b0);
    check_reset_state();
    start(16'h1000, 1'b0, due); exp_l(due, 16'h0100, 5'd12); exp_u(due, 16'h1000, 5'd0); finish(0);
    start(16'h1000, 1'b0, due); exp_l(due, 16'h01F0, 5'd12); exp_u(due, 16'h1000, 5'd0); finish(0);
    start(16'h1000, 1'b0, due); exp_l(due, 16'h02D1, 5'd12); exp_u(due, 16'h1000, 5'd0); finish(0);
    start(16'h1000, 1'b0, due); exp_l(due, 16'h03A3, 5'd12); exp_u(due, 16'h1000, 5'd0); finish(0);
    idle(4);

    // Saturation at both rails with 255/255 gains.
    do_reset(1'b0);
    start(16'h7FFF, 1'b0, due); exp_h(due, 16'h7FFF, 5'd17); exp_u(due, 16'h7FFF, 5'd0); finish(0);
    start(16'h8000, 1'b0, due); exp_h(due, 16'h8000, 5'd17); exp_u(due, 16'h8000, 5'd0); finish(0);
    idle(4);

    // Interleaved channels: right stays at zero, left follows its step.
    do_reset(1'b0);
    start(16'h1000, 1'b0, due); exp_l(due, 16'h0100, 5'd12); finish(0);
    start(16'h0000, 1'b1, due); exp_l(due, 16'h0000, 5'd0);  finish(0);
    start(16'h1000, 1'b0, due); exp_l(due, 16'h01F0, 5'd12); finish(0);
    start(16'h0000, 1'b1, due); exp_l(due, 16'h0000, 5'd0);  finish(0);
    start(16'h1000, 1'b0, due); exp_l(due, 16'h02D1, 5'd12); finish(0);
    idle(4);

    // SFS already high across reset release must not produce a sample.
    D = 16'h5555; LR = 1'b0;
    do_reset(1'b1);
    for (int i = 1; i <= 5; i++) exp_u(cyc + i, 16'h0000, 5'd0);
    check_reset_state();
    idle(3);
    #1 SFS = 1'b0;
    idle(4);

    // Reset one cycle after a strobe discards the in-flight sample.
    start(16'h1234, 1'b0, due);
    @(posedge SCK); #1;
    reset_n = 1'b0; SFS = 1'b0;
    @(posedge SCK); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_u(due + i, 16'h0000, 5'd0);
      exp_h(due + i, 16'h0000, 5'd0);
    end
    idle(8);

    n_vec++;
    if (q_u.size() + q_l.size() + q_h.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0",
               q_u.size() + q_l.size() + q_h.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/digital_equalizer.md
DIGITAL_EQUALIZER -- requirements
Module: digital_equalizer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width in bits, two's complement.
REQ-002 SHALL have parameter ALPHA_SHIFT, default 4: low-band one-pole smoothing shift, legal range 1..8.
REQ-003 SHALL have parameter LOW_GAIN, default 64: low-band gain, unsigned 8-bit Q2.6, where 64 = unity.
REQ-004 SHALL have parameter HIGH_GAIN, default 64: high-band gain, unsigned 8-bit Q2.6, where 64 = unity.
REQ-005 SHALL have port SCK, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port SFS, input, 1 bit: frame sync; each 0->1 transition marks one new input sample.
REQ-008 SHALL have port D, input, DATA_W bits: signed input sample, valid in the cycle SFS is first seen high.
REQ-009 SHALL have port LR, input, 1 bit: channel of the sample on D (0 = left, 1 = right), sampled with D.
REQ-010 SHALL have port D_out, output, DATA_W bits: equalized signed sample, held between updates.
REQ-011 SHALL have port EQ_out, output, 5 bits: magnitude class of the equalizer correction for the last output.

Function
REQ-012 SHALL register SFS and generate a one-cycle strobe when SFS=1 and the registered SFS=0; SFS held high for N cycles yields exactly one strobe.
REQ-013 SHALL capture D and LR into a sample register in the strobe cycle; D/LR are ignored in all other cycles.
REQ-014 SHALL keep independent per-channel low-band state lo_L and lo_R, each DATA_W+2 bits signed.
REQ-015 Stage 1, cycle after capture, for selected channel: lo_new = lo + ((x - lo) >>> ALPHA_SHIFT) (arithmetic shift); hi = x - lo_new; SHALL update only the selected channel's state.
REQ-016 Stage 2: y = (LOW_GAIN*lo_new + HIGH_GAIN*hi) >>> 6, using full-precision intermediate arithmetic with no internal overflow.
REQ-017 SHALL update D_out to y saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1] on the 2nd rising edge after the strobe edge (latency 2).
REQ-018 SHALL update EQ_out on the same edge as D_out to the bit length of |y - x| using unsaturated y: 0 when equal, 1 for difference 1, k for difference in [2^(k-1), 2^k-1], clipped to 31.
REQ-019 With LOW_GAIN = HIGH_GAIN = 64, SHALL output D_out = x exactly and EQ_out = 0 for every sample.
REQ-020 A strobe arriving while an earlier sample is still in the pipeline SHALL be accepted; the pipeline is fully pipelined at one sample per cycle with in-order outputs.
REQ-021 SHALL keep state consistent for back-to-back same-channel strobes: the second sample's stage 1 uses the state written by the first.

Reset
REQ-022 When reset_n=0 at a rising SCK edge: D_out=0, EQ_out=0, lo_L=lo_R=0, registered SFS=1 (no strobe from reset release with SFS already high), pipeline valids cleared.
REQ-023 Reset asserted mid-operation SHALL discard in-flight samples; no output update SHALL occur from them.

Configuration
REQ-024 With macro DEQ_BYPASS_EN defined, SHALL add input BYPASS (1 bit); while BYPASS=1, D_out = captured x (latency 2), EQ_out = 0, and filter state still updates.
REQ-025 Without DEQ_BYPASS_EN, SHALL have no BYPASS port and always equalize.

Structure
REQ-026 Package digital_equalizer_pkg SHALL hold the DATA_W default, the Q2.6 unity constant (64), the EQ_out width (5), and the saturate and bit-length helper functions.
REQ-027 The per-channel one-pole split (REQ-014/015) SHALL be a sub-module deq_band_split, instantiated once and muxed by captured LR.

Verification
REQ-028 Reset, then SFS pulses with D=16'h0000, 16'hFFFF, 16'h7FFF (unity gains) -> D_out = 0000, FFFF, 7FFF, each 2 cycles after its strobe; EQ_out = 0 throughout.
REQ-029 SFS held high 5 cycles with D changing each cycle -> exactly one output, equal to D in the first high cycle.
REQ-030 HIGH_GAIN=0, LOW_GAIN=64, ALPHA_SHIFT=4, left-channel step D=16'h1000 repeated -> first D_out=16'h0100, EQ_out=12, rising monotonically toward 16'h1000.
REQ-031 LOW_GAIN=HIGH_GAIN=255, D=16'h7FFF -> D_out=16'h7FFF (saturated); D=16'h8000 -> D_out=16'h8000.
REQ-032 Alternate LR=0/1 samples of 16'h1000 and 16'h0000 with HIGH_GAIN=0 -> right-channel outputs stay 0; left-channel outputs follow the step.
REQ-033 Assert reset_n=0 one cycle after a strobe -> no D_out update; D_out=0 and EQ_out=0 after reset.
